// File: rtl/dmem_access_seq.sv
// DMem access sequencer: turns one granted Length/Stride/Base request into
// a stream of strided word addresses under a valid/ready handshake, then
// pulses the terminate line of the granted lane so the handler releases it.
module dmem_access_seq #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned STRIDE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                I_Req,
  input  logic                I_GrantVld,
  input  logic [1:0]          I_GrantNo,
  input  logic [ADDR_W-1:0]   I_Length,
  input  logic [STRIDE_W-1:0] I_Stride,
  input  logic [ADDR_W-1:0]   I_Base_Addr,
  input  logic                I_Ready,
  output logic [ADDR_W-1:0]   O_Addr,
  output logic                O_Addr_Vld,
  output logic                O_Last,
  output logic                O_Term1,
  output logic                O_Term2,
  output logic                O_Term3,
  output logic                O_Busy,
  output logic [ADDR_W-1:0]   O_Beat_Cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TERM = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   len_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [1:0]          lane_q;

  logic [ADDR_W-1:0]   stride_ext;
  logic [ADDR_W-1:0]   cnt_nxt;
  logic [ADDR_W-1:0]   len_m1;
  logic                start;
  logic                accept;

  // I_Req is informational only; a held, non-zero grant is what starts an access.
  logic unused_req;
  assign unused_req = I_Req;

  // The address and beat count registers drive the ports directly.
  assign O_Addr     = addr_q;
  assign O_Beat_Cnt = cnt_q;

  // Next-beat arithmetic and handshake decode.
  always_comb begin
    stride_ext = ADDR_W'(stride_q);
    cnt_nxt    = cnt_q + ADDR_W'(1);
    len_m1     = len_q - ADDR_W'(1);
    start      = I_GrantVld && (I_GrantNo != 2'b00);
    accept     = O_Addr_Vld && I_Ready;
  end

  // Sequencer FSM with registered handshake, last-beat and terminate outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      stride_q   <= '0;
      lane_q     <= '0;
      O_Addr_Vld <= 1'b0;
      O_Last     <= 1'b0;
      O_Term1    <= 1'b0;
      O_Term2    <= 1'b0;
      O_Term3    <= 1'b0;
      O_Busy     <= 1'b0;
    end else begin
      O_Term1 <= 1'b0;
      O_Term2 <= 1'b0;
      O_Term3 <= 1'b0;
      case (state)
        IDLE: begin
          O_Addr_Vld <= 1'b0;
          O_Last     <= 1'b0;
          O_Busy     <= 1'b0;
          if (start) begin
            len_q    <= I_Length;
            stride_q <= I_Stride;
            addr_q   <= I_Base_Addr;
            lane_q   <= I_GrantNo;
            cnt_q    <= '0;
            O_Busy   <= 1'b1;
            if (I_Length != '0) begin
              state      <= RUN;
              O_Addr_Vld <= 1'b1;
              O_Last     <= (I_Length == ADDR_W'(1));
            end else begin
              // Zero-length access: skip RUN and terminate straight away.
              state   <= TERM;
              O_Term1 <= (I_GrantNo == 2'b01);
              O_Term2 <= (I_GrantNo == 2'b10);
              O_Term3 <= (I_GrantNo == 2'b11);
            end
          end
        end
        RUN: begin
          if (accept) begin
            addr_q <= addr_q + stride_ext;
            cnt_q  <= cnt_nxt;
            if (O_Last) begin
              state      <= TERM;
              O_Addr_Vld <= 1'b0;
              O_Last     <= 1'b0;
              O_Term1    <= (lane_q == 2'b01);
              O_Term2    <= (lane_q == 2'b10);
              O_Term3    <= (lane_q == 2'b11);
            end else begin
              O_Last <= (cnt_nxt == len_m1);
            end
          end
        end
        TERM: begin
          state      <= IDLE;
          O_Addr_Vld <= 1'b0;
          O_Last     <= 1'b0;
          O_Busy     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          O_Addr_Vld <= 1'b0;
          O_Last     <= 1'b0;
          O_Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_seq.sv
// Bench for dmem_access_seq: per-cycle vector table plus hand-written
// reset-during-run sequence.
module tb_dmem_access_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Req;
  logic        I_GrantVld;
  logic [1:0]  I_GrantNo;
  logic [15:0] I_Length;
  logic [15:0] I_Stride;
  logic [15:0] I_Base_Addr;
  logic        I_Ready;
  logic [15:0] O_Addr;
  logic        O_Addr_Vld;
  logic        O_Last;
  logic        O_Term1;
  logic        O_Term2;
  logic        O_Term3;
  logic        O_Busy;
  logic [15:0] O_Beat_Cnt;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_access_seq #(.ADDR_W(16), .STRIDE_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .I_Req      (I_Req),
    .I_GrantVld (I_GrantVld),
    .I_GrantNo  (I_GrantNo),
    .I_Length   (I_Length),
    .I_Stride   (I_Stride),
    .I_Base_Addr(I_Base_Addr),
    .I_Ready    (I_Ready),
    .O_Addr     (O_Addr),
    .O_Addr_Vld (O_Addr_Vld),
    .O_Last     (O_Last),
    .O_Term1    (O_Term1),
    .O_Term2    (O_Term2),
    .O_Term3    (O_Term3),
    .O_Busy     (O_Busy),
    .O_Beat_Cnt (O_Beat_Cnt)
  );

  always #5 clock = ~clock;

  // One record per clock: inputs driven before the edge, outputs expected after it.
  typedef struct {
    logic        rst;
    logic        gvld;
    logic [1:0]  gno;
    logic [15:0] len;
    logic [15:0] stride;
    logic [15:0] base;
    logic        rdy;
    logic [15:0] addr;
    logic        vld;
    logic        last;
    logic [2:0]  term;   // {Term3, Term2, Term1}
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[$];

  task automatic v(input logic rst, input logic gvld, input logic [1:0] gno,
                   input logic [15:0] len, input logic [15:0] stride,
                   input logic [15:0] base, input logic rdy,
                   input logic [15:0] addr, input logic vld, input logic last,
                   input logic [2:0] term, input logic busy, input logic [15:0] cnt);
    vec_t r;
    r.rst = rst; r.gvld = gvld; r.gno = gno; r.len = len; r.stride = stride;
    r.base = base; r.rdy = rdy; r.addr = addr; r.vld = vld; r.last = last;
    r.term = term; r.busy = busy; r.cnt = cnt;
    vt.push_back(r);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%04h, expected 0x%04h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic gvld, input logic [1:0] gno,
                       input logic [15:0] len, input logic [15:0] stride,
                       input logic [15:0] base, input logic rdy);
    reset = rst; I_GrantVld = gvld; I_Req = gvld; I_GrantNo = gno;
    I_Length = len; I_Stride = stride; I_Base_Addr = base; I_Ready = rdy;
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_addr"}, -1, O_Addr, 16'h0000);
    check({name, "_vld"},  -1, {15'd0, O_Addr_Vld}, 16'h0);
    check({name, "_last"}, -1, {15'd0, O_Last}, 16'h0);
    check({name, "_term"}, -1, {13'd0, O_Term3, O_Term2, O_Term1}, 16'h0);
    check({name, "_busy"}, -1, {15'd0, O_Busy}, 16'h0);
    check({name, "_cnt"},  -1, O_Beat_Cnt, 16'h0000);
  endtask

  logic [15:0] seen_addr[$];
  logic        term_seen;
  logic [2:0]  term_at;
  logic [15:0] cnt_at;

  initial begin
    // Lane 1, base 0x100, stride 4, length 4; later inputs change but are ignored.
    v(0,1,2'd1,16'd4,16'd4,16'h0100,1, 16'h0100,1,0,3'b000,1,16'd0);
    v(0,1,2'd2,16'd7,16'd1,16'h0555,1, 16'h0104,1,0,3'b000,1,16'd1);
    v(0,1,2'd2,16'd7,16'd1,16'h0555,1, 16'h0108,1,0,3'b000,1,16'd2);
    v(0,1,2'd2,16'd7,16'd1,16'h0555,1, 16'h010C,1,1,3'b000,1,16'd3);
    v(0,1,2'd2,16'd7,16'd1,16'h0555,1, 16'h0000,0,0,3'b001,1,16'd4);
    v(0,1,2'd2,16'd7,16'd1,16'h0555,1, 16'h0000,0,0,3'b000,0,16'd4);
    v(0,0,2'd0,16'd0,16'd0,16'h0000,1, 16'h0000,0,0,3'b000,0,16'd4);
    // Lane 3 with address wrap.
    v(0,1,2'd3,16'd3,16'd1,16'hFFFE,1, 16'hFFFE,1,0,3'b000,1,16'd0);
    v(0,1,2'd3,16'd3,16'd1,16'hFFFE,1, 16'hFFFF,1,0,3'b000,1,16'd1);
    v(0,1,2'd3,16'd3,16'd1,16'hFFFE,1, 16'h0000,1,1,3'b000,1,16'd2);
    v(0,1,2'd3,16'd3,16'd1,16'hFFFE,1, 16'h0000,0,0,3'b100,1,16'd3);
    v(0,0,2'd0,16'd0,16'd0,16'h0000,1, 16'h0000,0,0,3'b000,0,16'd3);
    // Lane 2 with ready pattern 1,0,0,1,1.
    v(0,1,2'd2,16'd3,16'd2,16'h0020,1, 16'h0020,1,0,3'b000,1,16'd0);
    v(0,1,2'd2,16'd3,16'd2,16'h0020,1, 16'h0022,1,0,3'b000,1,16'd1);
    v(0,1,2'd2,16'd3,16'd2,16'h0020,0, 16'h0022,1,0,3'b000,1,16'd1);
    v(0,1,2'd2,16'd3,16'd2,16'h0020,0, 16'h0022,1,0,3'b000,1,16'd1);
    v(0,1,2'd2,16'd3,16'd2,16'h0020,1, 16'h0024,1,1,3'b000,1,16'd2);
    v(0,1,2'd2,16'd3,16'd2,16'h0020,1, 16'h0000,0,0,3'b010,1,16'd3);
    v(0,0,2'd0,16'd0,16'd0,16'h0000,1, 16'h0000,0,0,3'b000,0,16'd3);
    // Zero length on lane 1: terminate without any address.
    v(0,1,2'd1,16'd0,16'd5,16'h0077,1, 16'h0000,0,0,3'b001,1,16'd0);
    v(0,0,2'd0,16'd0,16'd0,16'h0000,1, 16'h0000,0,0,3'b000,0,16'd0);
    // Grant held with lane 00 is ignored.
    v(0,1,2'd0,16'd4,16'd1,16'h0010,1, 16'h0000,0,0,3'b000,0,16'd0);
    v(0,1,2'd0,16'd4,16'd1,16'h0010,1, 16'h0000,0,0,3'b000,0,16'd0);
    // Length 1 on lane 3 with a stall: last on the first beat.
    v(0,1,2'd3,16'd1,16'd9,16'h1234,0, 16'h1234,1,1,3'b000,1,16'd0);
    v(0,0,2'd0,16'd0,16'd0,16'h0000,0, 16'h1234,1,1,3'b000,1,16'd0);
    v(0,0,2'd0,16'd0,16'd0,16'h0000,1, 16'h0000,0,0,3'b100,1,16'd1);
    v(0,0,2'd0,16'd0,16'd0,16'h0000,1, 16'h0000,0,0,3'b000,0,16'd1);

    // Reset state.
    drive(1,0,2'd0,16'd0,16'd0,16'h0000,0);
    repeat (2) @(posedge clock);
    #1;
    check_idle_zero("reset");

    // Table-driven vectors.
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clock);
      drive(vt[i].rst, vt[i].gvld, vt[i].gno, vt[i].len, vt[i].stride, vt[i].base, vt[i].rdy);
      @(posedge clock);
      #1;
      if (vt[i].vld) check("addr", i, O_Addr, vt[i].addr);
      check("addr_vld", i, {15'd0, O_Addr_Vld}, {15'd0, vt[i].vld});
      check("last",     i, {15'd0, O_Last},     {15'd0, vt[i].last});
      check("term",     i, {13'd0, O_Term3, O_Term2, O_Term1}, {13'd0, vt[i].term});
      check("busy",     i, {15'd0, O_Busy},     {15'd0, vt[i].busy});
      check("beat_cnt", i, O_Beat_Cnt, vt[i].cnt);
    end

    // Reset during RUN after 2 of 5 beats, then a fresh access on lane 2.
    @(negedge clock);
    drive(0,1,2'd1,16'd5,16'd8,16'h0300,1);
    repeat (3) @(posedge clock);
    #1;
    check("mid_cnt",  -1, O_Beat_Cnt, 16'd2);
    check("mid_addr", -1, O_Addr, 16'h0310);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_idle_zero("midrst");
    @(negedge clock);
    drive(0,0,2'd0,16'd0,16'd0,16'h0000,1);
    @(posedge clock);
    #1;
    check_idle_zero("postrst");

    @(negedge clock);
    drive(0,1,2'd2,16'd2,16'd1,16'h0400,1);
    @(posedge clock);
    #1;
    check("restart_cnt",  -1, O_Beat_Cnt, 16'd0);
    check("restart_addr", -1, O_Addr, 16'h0400);
    @(negedge clock);
    I_GrantVld = 1'b0;
    I_Req      = 1'b0;
    term_seen  = 1'b0;
    term_at    = 3'b000;
    cnt_at     = 16'h0000;
    for (int c = 0; c < 20; c++) begin
      if (O_Addr_Vld && I_Ready) seen_addr.push_back(O_Addr);
      if (O_Term1 || O_Term2 || O_Term3) begin
        term_seen = 1'b1;
        term_at   = {O_Term3, O_Term2, O_Term1};
        cnt_at    = O_Beat_Cnt;
        break;
      end
      @(negedge clock);
    end
    check("restart_term_seen", -1, {15'd0, term_seen}, 16'h1);
    check("restart_term_lane", -1, {13'd0, term_at}, 16'h2);
    check("restart_beats",     -1, 16'(seen_addr.size()), 16'd2);
    if (seen_addr.size() == 2) begin
      check("restart_addr0", -1, seen_addr[0], 16'h0400);
      check("restart_addr1", -1, seen_addr[1], 16'h0401);
    end
    check("restart_final_cnt", -1, cnt_at, 16'd2);
    @(negedge clock);
    check("restart_idle_busy", -1, {15'd0, O_Busy}, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
